// File: rtl/palindrome_pkg.sv
// palindrome_pkg: shared FSM state encoding, default word width and the mirror helper
package palindrome_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
    localparam int DEF_WIDTH = 8;
    function automatic logic [DEF_WIDTH-1:0] mirror(input logic [DEF_WIDTH/2-1:0] half);
        logic [DEF_WIDTH/2-1:0] rev;
        for (int i = 0; i < DEF_WIDTH/2; i++) rev[i] = half[DEF_WIDTH/2-1-i];
        return {half, rev};
    endfunction
endpackage

// File: rtl/palindrome_mirror.sv
// palindrome_mirror: combinational half -> {half, bitrev(half)}; ports: half (WIDTH/2) in, word (WIDTH) out
module palindrome_mirror import palindrome_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH/2-1:0] half,
    output logic [WIDTH-1:0]   word
);
    for (genvar i = 0; i < WIDTH/2; i++) begin : g_bit
        assign word[WIDTH-1-i] = half[WIDTH/2-1-i];
        assign word[i]         = half[WIDTH/2-1-i];
    end
endmodule

// File: rtl/palindrome_seq_tx.sv
// palindrome_seq_tx: mirrors a half-word into a palindrome and shifts it out MSB first
// ports: clk, rst (sync, active-high); in_half/in_valid/in_ready handshake;
// ser_out/ser_valid/ser_last serial stream; busy; last_word; frames_sent (8-bit wrap)
module palindrome_seq_tx import palindrome_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH/2-1:0] in_half,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               ser_last,
    output logic               busy,
    output logic [WIDTH-1:0]   last_word,
    output logic [7:0]         frames_sent
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    state_e          state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, last_q, last_d, word;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [7:0]       frames_q, frames_d;
    logic             accept, end_bit;
    palindrome_mirror #(.WIDTH(WIDTH)) u_mirror (.half(in_half), .word(word));
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (end_bit) state_d = GAP_CYCLES == 0 ? IDLE : GAP;
            GAP:     if (gap_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready    = state_q == IDLE && !rst;
        accept      = in_valid && in_ready;
        ser_valid   = state_q == SHIFT;
        end_bit     = ser_valid && cnt_q == '0;
        ser_out     = ser_valid && sh_q[WIDTH-1];
        ser_last    = end_bit;
        busy        = state_q != IDLE;
        last_word   = last_q;
        frames_sent = frames_q;
    end
    // the gap counter is preloaded on the final bit so GAP lasts exactly GAP_CYCLES cycles
    always_comb begin
        sh_d     = accept ? word : (ser_valid ? sh_q << 1 : sh_q);
        cnt_d    = accept ? CW'(WIDTH-1) : (ser_valid ? cnt_q - CW'(1) : cnt_q);
        gap_d    = end_bit ? GW'(GAP_CYCLES > 0 ? GAP_CYCLES-1 : 0) : (state_q == GAP ? gap_q - GW'(1) : gap_q);
        last_d   = accept ? word : last_q;
        frames_d = frames_q + 8'(end_bit);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            last_q   <= '0;
            frames_q <= '0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            frames_q <= frames_d;
        end
    end
endmodule

// File: tb/tb_palindrome_seq_tx.sv
// tb_palindrome_seq_tx: randomized self-checking bench against a serial-order reference model
module tb_palindrome_seq_tx;
    localparam int W = 8;
    localparam int H = W/2;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [H-1:0] in_half;
    logic in_valid, in_ready, ser_out, ser_valid, ser_last, busy;
    logic [W-1:0] last_word;
    logic [7:0] frames_sent;
    logic [H-1:0] a_half;
    logic a0_valid, a0_ready, a0_out, a0_sv, a0_last, a0_busy;
    logic a3_valid, a3_ready, a3_out, a3_sv, a3_last, a3_busy;
    logic [W-1:0] a0_lw, a3_lw;
    logic [7:0] a0_fs, a3_fs;
    logic [0:0] w_half;
    logic w_valid, w_ready, w_out, w_sv, w_last, w_busy;
    logic [1:0] w_lw;
    logic [7:0] w_fs;
    palindrome_seq_tx #(.WIDTH(W), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_half(in_half), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy),
        .last_word(last_word), .frames_sent(frames_sent));
    palindrome_seq_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .in_half(a_half), .in_valid(a0_valid), .in_ready(a0_ready),
        .ser_out(a0_out), .ser_valid(a0_sv), .ser_last(a0_last), .busy(a0_busy),
        .last_word(a0_lw), .frames_sent(a0_fs));
    palindrome_seq_tx #(.WIDTH(W), .GAP_CYCLES(3)) dut_g3 (
        .clk(clk), .rst(rst), .in_half(a_half), .in_valid(a3_valid), .in_ready(a3_ready),
        .ser_out(a3_out), .ser_valid(a3_sv), .ser_last(a3_last), .busy(a3_busy),
        .last_word(a3_lw), .frames_sent(a3_fs));
    palindrome_seq_tx #(.WIDTH(2), .GAP_CYCLES(1)) dut_w2 (
        .clk(clk), .rst(rst), .in_half(w_half), .in_valid(w_valid), .in_ready(w_ready),
        .ser_out(w_out), .ser_valid(w_sv), .ser_last(w_last), .busy(w_busy),
        .last_word(w_lw), .frames_sent(w_fs));
    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int acc_cyc = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    // wire order: half MSB-first, then the same half LSB-first
    function automatic logic [31:0] model_word(input int half, input int hw);
        logic [31:0] w = 0;
        for (int i = hw-1; i >= 0; i--) w = (w << 1) | 32'((half >> i) & 1);
        for (int i = 0; i < hw; i++) w = (w << 1) | 32'((half >> i) & 1);
        return w;
    endfunction
    function automatic logic is_pal(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) if (w[i] != w[n-1-i]) return 1'b0;
        return 1'b1;
    endfunction
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);
    endtask
    task automatic send(input logic [H-1:0] h, input logic hold);
        wait_ready();
        in_half = h;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = hold;
    endtask
    task automatic recv(input logic [H-1:0] h);
        logic [W-1:0] got = '0;
        int nv = 0, nl = 0, lastpos = -1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            got = {got[W-2:0], ser_out};
            nv += int'(ser_valid);
            if (ser_last) begin
                nl++;
                lastpos = i;
            end
        end
        check("word", 32'(got), model_word(int'(h), H));
        check("valid_cnt", nv, W);
        check("last_pos", lastpos, W-1);
        check("last_cnt", nl, 1);
        check("symmetry", 32'(is_pal(32'(got), W)), 1);
        check("last_word", 32'(last_word), model_word(int'(h), H));
        @(negedge clk);
        exp_frames = (exp_frames + 1) % 256;
        check("frames", 32'(frames_sent), exp_frames);
        check("gap_ready", in_ready, 0);
        check("gap_valid", ser_valid, 0);
        check("gap_out", ser_out, 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int prev, l0, r0, l3, r3, k;
        logic [W-1:0] g0w, g3w;
        logic [1:0] ww;
        logic [H-1:0] h;
        rst = 1'b1;
        in_valid = 1'b0; in_half = '0;
        a0_valid = 1'b0; a3_valid = 1'b0; a_half = '0;
        w_valid = 1'b0; w_half = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_valid", ser_valid, 0);
        check("rst_out", ser_out, 0);
        check("rst_last", ser_last, 0);
        check("rst_busy", busy, 0);
        check("rst_lw", 32'(last_word), 0);
        check("rst_frames", 32'(frames_sent), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
        send(4'hB, 1'b0);
        check("busy_shift", busy, 1);
        recv(4'hB);
        check("bd_literal", 32'(last_word), 32'hBD);
        send(4'hB, 1'b0);
        in_half = 4'h3;
        in_valid = 1'b1;
        recv(4'hB);
        send(4'h3, 1'b0);
        recv(4'h3);
        check("3c_literal", 32'(last_word), 32'h3C);
        send(4'h6, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_valid", ser_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        check("abort_valid", ser_valid, 0);
        check("abort_out", ser_out, 0);
        check("abort_frames", 32'(frames_sent), 0);
        check("abort_busy", busy, 0);
        check("abort_lw", 32'(last_word), 0);
        rst = 1'b0;
        #1;
        check("abort_ready", in_ready, 1);
        exp_frames = 0;
        prev = 0;
        for (int f = 0; f < 256; f++) begin
            h = H'($urandom);
            send(h, 1'b1);
            if (f > 0) check("period", acc_cyc - prev, W + 2);
            prev = acc_cyc;
            recv(h);
        end
        in_valid = 1'b0;
        check("wrap", 32'(frames_sent), 0);
        for (int v = 0; v < 16; v++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(H'(v), 1'b0);
            recv(H'(v));
        end
        @(negedge clk);
        a_half = H'($urandom);
        check("aux_ready", 32'({a0_ready, a3_ready}), 32'h3);
        a0_valid = 1'b1;
        a3_valid = 1'b1;
        @(posedge clk);
        #1;
        a0_valid = 1'b0;
        a3_valid = 1'b0;
        l0 = -1; r0 = -1; l3 = -1; r3 = -1;
        g0w = '0; g3w = '0;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (a0_sv) g0w = {g0w[W-2:0], a0_out};
            if (a3_sv) g3w = {g3w[W-2:0], a3_out};
            if (a0_last) l0 = k;
            if (a3_last) l3 = k;
            if (a0_ready && l0 >= 0 && r0 < 0) r0 = k;
            if (a3_ready && l3 >= 0 && r3 < 0) r3 = k;
        end
        check("g0_rise", r0 - l0, 1);
        check("g3_rise", r3 - l3, 4);
        check("g0_word", 32'(g0w), model_word(int'(a_half), H));
        check("g3_word", 32'(g3w), model_word(int'(a_half), H));
        for (int v = 0; v < 2; v++) begin
            k = 0;
            while (!w_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            w_half = 1'(v);
            w_valid = 1'b1;
            @(posedge clk);
            #1;
            w_valid = 1'b0;
            ww = '0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                ww = {ww[0], w_out};
            end
            check("w2_word", 32'(ww), model_word(v, 1));
            check("w2_lw", 32'(w_lw), model_word(v, 1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
